maxpool2d: RTL and testbench
============================

Name: maxpool2d

Overview:
- Stage directly downstream of the convolution layer. It reads the conv feature-map memory (layout x + y*IN_WIDTH + c*IN_WIDTH*IN_HEIGHT) through an address/valid read interface.
- Performs non-overlapping POOL x POOL max pooling (stride = POOL) per channel.
- Writes pooled words to the next layer's buffer with an address/valid pulse, then pulses pool_done.
- One window is processed at a time; no line buffering.

Parameters:
- IN_WIDTH, 62: feature-map width (conv output width).
- IN_HEIGHT, 62: feature-map height.
- CHANNELS, 30: number of feature maps (conv neurons).
- POOL, 2: pool window side and stride; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start request, sampled in IDLE only.
- input_data  in  16 signed  feature-map word at input_addr.
- input_addr  out  $clog2(IN_WIDTH*IN_HEIGHT*CHANNELS)  read address.
- input_req  out  1  read request; input_addr is held stable while high.
- input_valid  in  1  input_data is valid for the current input_addr.
- pooled_data  out  16 signed  pooled result.
- output_addr  out  $clog2(OW*OH*CHANNELS)  write address, where OW = IN_WIDTH/POOL and OH = IN_HEIGHT/POOL (integer floor).
- output_valid  out  1  one-cycle write strobe.
- pool_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE.
  - All outputs and counters 0; running max 0.
  - Reset mid-operation aborts the frame; no output_valid or pool_done follows.
- States:
  - IDLE -> LOAD on enable.
  - LOAD -> STORE after POOL*POOL accepted words.
  - STORE -> LOAD, or STORE -> DONE after the last output.
  - DONE -> IDLE.
- IDLE:
  - input_req=0, output_valid=0.
  - On enable: clear ox, oy, ch, window counters (wx, wy), k; go to LOAD.
- LOAD:
  - input_req=1; input_addr = (ox*POOL+wx) + (oy*POOL+wy)*IN_WIDTH + ch*IN_WIDTH*IN_HEIGHT.
  - A word is accepted on a cycle with input_req=1 and input_valid=1.
  - Word k=0 loads the running max directly. Words k>0 use max = (input_data > max) ? input_data : max, as a signed 16-bit compare.
  - Window scan order: wx fastest, then wy. The address advances on the cycle after acceptance.
  - input_valid low stalls indefinitely, with address and counters held.
- STORE:
  - input_req=0, output_valid=1 for exactly one cycle.
  - pooled_data = max; output_addr = ox + oy*OW + ch*OW*OH.
  - Iteration order: ox fastest, then oy, then ch, so output_addr increments by 1 per output from 0 to OW*OH*CHANNELS-1.
  - Last output (ox=OW-1, oy=OH-1, ch=CHANNELS-1) -> DONE; otherwise -> LOAD.
- DONE:
  - pool_done=1 for one cycle, output_valid=0 -> IDLE.
  - pool_done returns to 0 in IDLE.
- Latency:
  - Per output: POOL*POOL accept cycles + 1 STORE cycle.
  - With input_valid held high: POOL*POOL+1 cycles per output; first output_valid occurs 1+POOL*POOL+1 cycles after the enable sample.
- Boundaries:
  - Odd IN_WIDTH/IN_HEIGHT: the trailing column/row is never read.
  - enable while not IDLE is ignored.
  - enable held high in DONE restarts a new frame from IDLE on the next cycle.
  - Ties keep the earlier value; the result is identical either way.
  - Window containing all -32768 -> -32768.

Optional Feature:
- Macro POOL_RELU_EN.
- When defined: pooled_data = (max < 0) ? 0 : max, a fused ReLU applied in STORE only; the running max itself is unclamped.
- When undefined: pooled_data = max unchanged, including negative values.
- Timing and addressing are identical in both builds.

Decomposition:
- Shared package cnn_pkg:
  - 16-bit signed data word typedef.
  - State encoding shared with the conv stage: IDLE/LOAD/STORE/DONE localparams.
  - Address-index functions: feature-map index (x,y,c,W,H).
- Optional sub-module pool_max_acc: running-max register with load/compare enable and the signed compare; the FSM and address generation stay in maxpool2d.

Test Plan:
- 4x4x1 frame, values 0..15 row-major, input_valid tied 1, POOL=2 -> outputs 5,7,13,15 at output_addr 0..3; pool_done one cycle after the last STORE.
- Window {-5,-2,-9,-7} -> pooled_data=-2 without POOL_RELU_EN; 0 with POOL_RELU_EN defined.
- input_valid toggling 1,0,0,1,... -> input_addr held during stalls; results match the no-stall run; output_valid count = OW*OH*CHANNELS.
- 5x5x2 frame -> 2x2x2 = 8 outputs; row 4 and column 4 addresses never driven on input_addr; output_addr 0..7.
- reset asserted for 1 cycle during the 3rd LOAD -> all outputs 0 next cycle, no pool_done; a new enable produces the full correct frame.
- enable pulsed during LOAD -> ignored; exactly one pool_done per frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types: data word, stage state encoding
// and the feature-map index helper.
package cnn_pkg;

  typedef logic signed [15:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Layout x + y*W + c*W*H
  function automatic logic [31:0] fm_index(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] c,
    input logic [31:0] w,
    input logic [31:0] h
  );
    return x + y * w + c * w * h;
  endfunction

endpackage

// File: rtl/pool_max_acc.sv
// Running-max register for one pooling window.
// load takes the first word; cmp keeps the signed maximum.
module pool_max_acc
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  cmp,
  input  data_t din,
  output data_t max_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
    end else if (load) begin
      max_q <= din;
    end else if (cmp && (din > max_q)) begin
      max_q <= din;
    end
  end

endmodule

// File: rtl/maxpool2d.sv
// Non-overlapping POOLxPOOL max pooling over a conv feature map.
// Build option: define POOL_RELU_EN to clamp negative results to 0.
module maxpool2d
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH  = 62,
  parameter int IN_HEIGHT = 62,
  parameter int CHANNELS  = 30,
  parameter int POOL      = 2,
  localparam int OW  = IN_WIDTH / POOL,
  localparam int OH  = IN_HEIGHT / POOL,
  localparam int AW  = $clog2(IN_WIDTH * IN_HEIGHT * CHANNELS),
  localparam int OAW = $clog2(OW * OH * CHANNELS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  data_t          input_data,
  output logic [AW-1:0]  input_addr,
  output logic           input_req,
  input  logic           input_valid,
  output data_t          pooled_data,
  output logic [OAW-1:0] output_addr,
  output logic           output_valid,
  output logic           pool_done
);

  localparam logic [15:0] P_MAX  = 16'(POOL - 1);
  localparam logic [15:0] K_MAX  = 16'(POOL * POOL - 1);
  localparam logic [15:0] OX_MAX = 16'(OW - 1);
  localparam logic [15:0] OY_MAX = 16'(OH - 1);
  localparam logic [15:0] CH_MAX = 16'(CHANNELS - 1);

  state_t state, state_n;
  logic [15:0] ox, oy, ch, wx, wy, k;
  logic accept, win_last, out_last;
  data_t max_q;

  assign accept   = (state == LOAD) && input_valid;
  assign win_last = (k == K_MAX);
  assign out_last = (ox == OX_MAX) && (oy == OY_MAX)
                 && (ch == CH_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (enable) state_n = LOAD;
      LOAD:  if (accept && win_last) state_n = STORE;
      STORE: state_n = out_last ? DONE : LOAD;
      DONE:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ox <= '0; oy <= '0; ch <= '0;
      wx <= '0; wy <= '0; k  <= '0;
    end else begin
      case (state)
        IDLE: if (enable) begin
          ox <= '0; oy <= '0; ch <= '0;
          wx <= '0; wy <= '0; k  <= '0;
        end
        LOAD: if (accept) begin
          if (win_last) begin
            wx <= '0; wy <= '0; k <= '0;
          end else begin
            k <= k + 16'd1;
            if (wx == P_MAX) begin
              wx <= '0;
              wy <= wy + 16'd1;
            end else begin
              wx <= wx + 16'd1;
            end
          end
        end
        STORE: begin
          // Wrapping on the last output leaves counters at 0
          if (ox == OX_MAX) begin
            ox <= '0;
            if (oy == OY_MAX) begin
              oy <= '0;
              ch <= (ch == CH_MAX) ? '0 : ch + 16'd1;
            end else begin
              oy <= oy + 16'd1;
            end
          end else begin
            ox <= ox + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  pool_max_acc u_acc (
    .clk   (clk),
    .reset (reset),
    .load  (accept && (k == '0)),
    .cmp   (accept && (k != '0)),
    .din   (input_data),
    .max_q (max_q)
  );

  always_comb begin
    input_addr = AW'(fm_index(
      32'(ox) * 32'(POOL) + 32'(wx),
      32'(oy) * 32'(POOL) + 32'(wy),
      32'(ch), 32'(IN_WIDTH), 32'(IN_HEIGHT)));
    output_addr = OAW'(fm_index(
      32'(ox), 32'(oy), 32'(ch), 32'(OW), 32'(OH)));
  end

  assign input_req    = (state == LOAD);
  assign output_valid = (state == STORE);
  assign pool_done    = (state == DONE);

`ifdef POOL_RELU_EN
  assign pooled_data = max_q[15] ? '0 : max_q;
`else
  assign pooled_data = max_q;
`endif

endmodule

// File: tb/tb_maxpool2d.sv
// Scoreboard bench for maxpool2d: a 4x4x1 and a 5x5x2 instance
// sharing clock and reset.
module tb_maxpool2d;
  import cnn_pkg::*;

  localparam int AWA  = $clog2(16);
  localparam int OAWA = $clog2(4);
  localparam int AWB  = $clog2(50);
  localparam int OAWB = $clog2(8);

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en_a, en_b;
  logic val_a = 1'b1;
  logic val_b;
  data_t din_a, din_b, pd_a, pd_b;
  logic [AWA-1:0] ia_a;
  logic [AWB-1:0] ia_b;
  logic [OAWA-1:0] oa_a;
  logic [OAWB-1:0] oa_b;
  logic req_a, req_b, ov_a, ov_b, done_a, done_b;

  data_t mem_a [16];
  data_t mem_b [50];

  assign val_b = 1'b1;
  assign din_a = mem_a[ia_a];
  assign din_b = (int'(ia_b) < 50) ? mem_b[ia_b] : 16'sd0;

  maxpool2d #(
    .IN_WIDTH(4), .IN_HEIGHT(4), .CHANNELS(1), .POOL(2)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(en_a),
    .input_data(din_a), .input_addr(ia_a),
    .input_req(req_a), .input_valid(val_a),
    .pooled_data(pd_a), .output_addr(oa_a),
    .output_valid(ov_a), .pool_done(done_a)
  );

  maxpool2d #(
    .IN_WIDTH(5), .IN_HEIGHT(5), .CHANNELS(2), .POOL(2)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(en_b),
    .input_data(din_b), .input_addr(ia_b),
    .input_req(req_b), .input_valid(val_b),
    .pooled_data(pd_b), .output_addr(oa_b),
    .output_valid(ov_b), .pool_done(done_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int n_pass = 0;
  int n_chk  = 0;
  int ovc_a = 0, ovc_b = 0, donec_a = 0, donec_b = 0;
  int hold_err = 0, odd_err = 0, vcnt = 0;
  logic stall_a = 1'b0;
  logic prev_ov_a = 1'b0, prev_ov_b = 1'b0;
  logic prev_req_a = 1'b0, prev_val_a = 1'b1;
  logic [AWA-1:0] prev_ia_a = '0;

  task automatic check(input string name, input int act,
                       input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, want);
  endtask

  // Monitor A; also drives the stall pattern 1,0,0,...
  always @(negedge clk) begin
    if (ov_a) begin
      ovc_a++;
      check("a_ov_expected", int'(q_a.size() > 0), 1);
      if (q_a.size() > 0) begin
        exp_t e;
        e = q_a.pop_front();
        check("a_out_addr", int'(oa_a), e.addr);
        check("a_out_data", int'(pd_a), e.data);
      end
    end
    if (done_a) begin
      donec_a++;
      check("a_done_after_store", int'(prev_ov_a), 1);
    end
    if (req_a && prev_req_a && !prev_val_a && ia_a != prev_ia_a)
      hold_err++;
    prev_ov_a  = ov_a;
    prev_req_a = req_a;
    prev_ia_a  = ia_a;
    val_a = stall_a ? (vcnt % 3 == 0) : 1'b1;
    vcnt++;
    prev_val_a = val_a;
  end

  always @(negedge clk) begin
    if (ov_b) begin
      ovc_b++;
      check("b_ov_expected", int'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        exp_t e;
        e = q_b.pop_front();
        check("b_out_addr", int'(oa_b), e.addr);
        check("b_out_data", int'(pd_b), e.data);
      end
    end
    if (done_b) begin
      donec_b++;
      check("b_done_after_store", int'(prev_ov_b), 1);
    end
    if (req_b) begin
      int a;
      a = int'(ia_b);
      if (a >= 50 || (a % 25) % 5 == 4 || (a % 25) / 5 == 4)
        odd_err++;
    end
    prev_ov_b = ov_b;
  end

  task automatic fill_a_ramp();
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_req"},  int'(req_a),  0);
    check({tag, "_ov"},   int'(ov_a),   0);
    check({tag, "_done"}, int'(done_a), 0);
    check({tag, "_data"}, int'(pd_a),   0);
    check({tag, "_iadr"}, int'(ia_a),   0);
    check({tag, "_oadr"}, int'(oa_a),   0);
  endtask

  // Called at a negedge with the DUT idle
  task automatic frame_a(input int exp_d[4], input int pulse);
    int d0, o0, lat;
    d0 = donec_a;
    o0 = ovc_a;
    for (int i = 0; i < 4; i++) q_a.push_back('{i, exp_d[i]});
    en_a = 1'b1;
    lat = 1;
    @(negedge clk);
    en_a = 1'b0;
    lat = 2;
    while (!ov_a && lat < 100) begin
      @(negedge clk);
      lat++;
      en_a = (lat == pulse);
    end
    en_a = 1'b0;
    if (!stall_a) check("a_first_latency", lat, 6);
    for (int c = 0; c < 400 && donec_a == d0; c++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("a_done_count", donec_a - d0, 1);
    check("a_ov_count", ovc_a - o0, 4);
    check("a_queue_left", q_a.size(), 0);
  endtask

  task automatic abort_a();
    int d0, o0;
    d0 = donec_a;
    o0 = ovc_a;
    q_a.push_back('{0, 5});
    q_a.push_back('{1, 7});
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    for (int c = 0; c < 100 && ovc_a < o0 + 2; c++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    check("abort_in_load", int'(req_a), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_a_zero("abort");
    repeat (20) @(negedge clk);
    check("abort_no_done", donec_a - d0, 0);
    check("abort_ov_count", ovc_a - o0, 2);
    check("abort_queue_left", q_a.size(), 0);
  endtask

  task automatic frame_b();
    int d0, o0;
    int exp_d [8] = '{6, 8, 16, 18, 50, 48, 40, 38};
    d0 = donec_b;
    o0 = ovc_b;
    for (int i = 0; i < 8; i++) q_b.push_back('{i, exp_d[i]});
    en_b = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    for (int c = 0; c < 400 && donec_b == d0; c++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("b_done_count", donec_b - d0, 1);
    check("b_ov_count", ovc_b - o0, 8);
    check("b_queue_left", q_b.size(), 0);
    check("b_odd_edge_reads", odd_err, 0);
  endtask

  initial begin
    reset = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    fill_a_ramp();
    for (int j = 0; j < 25; j++) begin
      mem_b[j]      = 16'(j);
      mem_b[25 + j] = 16'(50 - j);
    end
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset_b_req", int'(req_b), 0);
    check("reset_b_oadr", int'(oa_b), 0);
    reset = 1'b0;
    @(negedge clk);

    frame_a('{5, 7, 13, 15}, -1);

    mem_a[0]  = -16'sd5;
    mem_a[1]  = -16'sd2;
    mem_a[4]  = -16'sd9;
    mem_a[5]  = -16'sd7;
    mem_a[2]  = -16'sd32768;
    mem_a[3]  = -16'sd32768;
    mem_a[6]  = -16'sd32768;
    mem_a[7]  = -16'sd32768;
    mem_a[8]  = 16'sd3;
    mem_a[9]  = 16'sd3;
    mem_a[12] = 16'sd3;
    mem_a[13] = 16'sd3;
    mem_a[10] = 16'sd100;
    mem_a[11] = -16'sd1;
    mem_a[14] = 16'sd32767;
    mem_a[15] = -16'sd32768;
`ifdef POOL_RELU_EN
    frame_a('{0, 0, 3, 32767}, -1);
`else
    frame_a('{-2, -32768, 3, 32767}, -1);
`endif

    fill_a_ramp();
    stall_a = 1'b1;
    frame_a('{5, 7, 13, 15}, -1);
    stall_a = 1'b0;
    check("a_stall_addr_hold", hold_err, 0);

    frame_b();

    frame_a('{5, 7, 13, 15}, 3);

    abort_a();
    frame_a('{5, 7, 13, 15}, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
